// File: rtl/sdram_arbiter.sv
// Multi-master front end for the SDRAM controller: grants one master at a time and routes the
// controller's per-master valid/complete pulses back. Define SDRAM_ARB_ROUND_ROBIN_EN for round robin.
module sdram_arbiter #(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_request,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [26*NUM_MASTERS-1:0] m_address,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_byte_en,
    input  logic [NUM_MASTERS-1:0]    m_burst,
    output logic [31:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]    m_valid,
    output logic [NUM_MASTERS-1:0]    m_complete,
    output logic                      sdram_request,
    output logic [3:0]                sdram_master,
    output logic                      sdram_write,
    output logic [25:0]               sdram_address,
    output logic [31:0]               sdram_wdata,
    output logic [3:0]                sdram_byte_en,
    output logic                      sdram_burst,
    input  logic [31:0]               sdram_rdata,
    input  logic [3:0]                sdram_valid,
    input  logic [3:0]                sdram_complete
);

    typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              last_q, last_d;
    logic                    req_q, req_d;
    logic [3:0]              master_q, master_d;
    logic                    write_q, write_d;
    logic [25:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    burst_q, burst_d;
    logic [NUM_MASTERS-1:0]  valid_q, valid_d;
    logic [NUM_MASTERS-1:0]  complete_q, complete_d;
    logic [31:0]             rdata_q, rdata_d;
    int unsigned             win;

    always_comb begin
        win = 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        // Scan downward so the first requester above last wins the final assignment.
        for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
            if (m_request[(int'(last_q) + k) % int'(NUM_MASTERS)]) begin
                win = (int'(last_q) + k) % int'(NUM_MASTERS);
            end
        end
`else
        for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
            if (m_request[i]) begin
                win = i;
            end
        end
`endif
    end

`ifndef SDRAM_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = ^last_q;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        req_d    = req_q;
        master_d = master_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        burst_d  = burst_q;
        rdata_d  = sdram_rdata;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            valid_d[i]    = (sdram_valid == 4'(i + 1));
            complete_d[i] = (sdram_complete == 4'(i + 1));
        end

        unique case (state_q)
            StIdle: begin
                if (|m_request) begin
                    req_d    = 1'b1;
                    master_d = 4'(win + 1);
                    last_d   = 4'(win);
                    write_d  = m_write[win];
                    addr_d   = m_address[26*win +: 26];
                    wdata_d  = m_wdata[32*win +: 32];
                    be_d     = m_byte_en[4*win +: 4];
                    burst_d  = m_burst[win];
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // Completions carrying another master's ID are not ours to act on.
                if (sdram_complete == master_q) begin
                    req_d   = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            last_q     <= 4'(NUM_MASTERS - 1);
            req_q      <= 1'b0;
            master_q   <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 26'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            burst_q    <= 1'b0;
            valid_q    <= '0;
            complete_q <= '0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            req_q      <= req_d;
            master_q   <= master_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            burst_q    <= burst_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
            rdata_q    <= rdata_d;
        end
    end

    assign sdram_request = req_q;
    assign sdram_master  = master_q;
    assign sdram_write   = write_q;
    assign sdram_address = addr_q;
    assign sdram_wdata   = wdata_q;
    assign sdram_byte_en = be_q;
    assign sdram_burst   = burst_q;
    assign m_valid       = valid_q;
    assign m_complete    = complete_q;
    assign m_rdata       = rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-level model checked every cycle, plus
// hand-computed expectations for the key scenarios.
module tb_sdram_arbiter;
    localparam int N = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    m_request, m_write, m_burst;
    logic [26*N-1:0] m_address;
    logic [32*N-1:0] m_wdata;
    logic [4*N-1:0]  m_byte_en;
    logic [31:0]     m_rdata;
    logic [N-1:0]    m_valid, m_complete;
    logic            sdram_request, sdram_write, sdram_burst;
    logic [3:0]      sdram_master, sdram_byte_en;
    logic [25:0]     sdram_address;
    logic [31:0]     sdram_wdata, sdram_rdata;
    logic [3:0]      sdram_valid, sdram_complete;

    sdram_arbiter #(.NUM_MASTERS(N)) dut (
        .clock(clock), .reset(reset),
        .m_request(m_request), .m_write(m_write), .m_address(m_address),
        .m_wdata(m_wdata), .m_byte_en(m_byte_en), .m_burst(m_burst),
        .m_rdata(m_rdata), .m_valid(m_valid), .m_complete(m_complete),
        .sdram_request(sdram_request), .sdram_master(sdram_master),
        .sdram_write(sdram_write), .sdram_address(sdram_address),
        .sdram_wdata(sdram_wdata), .sdram_byte_en(sdram_byte_en),
        .sdram_burst(sdram_burst), .sdram_rdata(sdram_rdata),
        .sdram_valid(sdram_valid), .sdram_complete(sdram_complete)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: phase 0 = idle, 1 = owned by a master, 2 = one settle cycle.
    int          ph, mlast, mw;
    logic        e_req, e_write, e_burst;
    logic [3:0]  e_master, e_be;
    logic [25:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    logic [N-1:0] e_valid, e_complete;

    function automatic int pick(input logic [N-1:0] req, input int after);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (req[(after + k) % N]) return (after + k) % N;
`else
        for (int i = 0; i < N; i++) if (req[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            ph = 0; mlast = N - 1;
            e_req = 0; e_master = 0; e_write = 0; e_addr = 0; e_wdata = 0; e_be = 0;
            e_burst = 0; e_valid = 0; e_complete = 0; e_rdata = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                e_valid[i]    = (sdram_valid == i + 1);
                e_complete[i] = (sdram_complete == i + 1);
            end
            e_rdata = sdram_rdata;
            if (ph == 0) begin
                mw = pick(m_request, mlast);
                if (mw >= 0) begin
                    e_req = 1; e_master = 4'(mw + 1); mlast = mw;
                    e_write = m_write[mw]; e_addr = m_address[26*mw +: 26];
                    e_wdata = m_wdata[32*mw +: 32]; e_be = m_byte_en[4*mw +: 4];
                    e_burst = m_burst[mw]; ph = 1;
                end
            end else if (ph == 1) begin
                if (sdram_complete == e_master) begin
                    e_req = 0; ph = 2;
                end
            end else begin
                ph = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("sdram_request", sdram_request, e_req);
            chk("sdram_master", sdram_master, e_master);
            chk("sdram_write", sdram_write, e_write);
            chk("sdram_address", sdram_address, e_addr);
            chk("sdram_wdata", sdram_wdata, e_wdata);
            chk("sdram_byte_en", sdram_byte_en, e_be);
            chk("sdram_burst", sdram_burst, e_burst);
            chk("m_valid", m_valid, e_valid);
            chk("m_complete", m_complete, e_complete);
            chk("m_rdata", m_rdata, e_rdata);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_master(input int i, input bit wr, input logic [25:0] a,
                              input logic [31:0] d, input logic [3:0] be, input bit bu);
        m_write[i] = wr;
        m_address[26*i +: 26] = a;
        m_wdata[32*i +: 32] = d;
        m_byte_en[4*i +: 4] = be;
        m_burst[i] = bu;
        m_request[i] = 1'b1;
    endtask

    task automatic wait_grant(output logic [3:0] id);
        int n = 0;
        while (!sdram_request && n < 50) begin
            tick;
            n++;
        end
        if (!sdram_request) chk("grant_timeout", 64'd0, 64'd1);
        id = sdram_request ? sdram_master : 4'd0;
    endtask

    // Plays the controller: beats of valid, complete on the last; returns in the DRAIN cycle.
    task automatic serve(input int beats, input logic [31:0] base, input bit keep,
                         input logic [3:0] exp_onehot, output logic [3:0] id);
        wait_grant(id);
        for (int b = 0; b < beats; b++) begin
            sdram_valid    = id;
            sdram_rdata    = base + 32'(b);
            sdram_complete = (b == beats - 1) ? id : 4'd0;
            tick;
            if (exp_onehot != 0) begin
                chk("beat_valid", m_valid, exp_onehot);
                chk("beat_rdata", m_rdata, base + 32'(b));
            end
        end
        sdram_valid = 0;
        sdram_complete = 0;
        sdram_rdata = 0;
        if (!keep && id != 0) m_request[id-1] = 1'b0;
    endtask

    logic [3:0] id;
    logic [3:0] exp_order [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; m_request = 0; m_write = 0; m_burst = 0;
        m_address = 0; m_wdata = 0; m_byte_en = 0;
        sdram_rdata = 0; sdram_valid = 0; sdram_complete = 0;
        tick;
        chk_en = 1'b1;
        tick;
        reset = 0;
        chk("rst_request", sdram_request, 1'b0);
        chk("rst_master", sdram_master, 4'd0);
        chk("rst_address", sdram_address, 26'd0);
        chk("rst_m_valid", m_valid, 4'd0);
        tick;

        // Reset while busy for master 1.
        set_master(1, 0, 26'h0000200, 32'h11111111, 4'hF, 0);
        wait_grant(id);
        chk("midrst_grant", id, 4'd2);
        tick;
        reset = 1;
        tick;
        chk("midrst_request", sdram_request, 1'b0);
        chk("midrst_master", sdram_master, 4'd0);
        chk("midrst_complete", m_complete, 4'd0);
        reset = 0;
        tick;
        chk("postrst_request", sdram_request, 1'b1);
        chk("postrst_master", sdram_master, 4'd2);
        serve(1, 32'h0, 0, 4'b0010, id);
        tick; tick;

        // Single write, master 0.
        set_master(0, 1, 26'h0001000, 32'hDEADBEEF, 4'hF, 0);
        serve(1, 32'h0, 0, 4'b0001, id);
        chk("wr_id", id, 4'd1);
        chk("wr_complete", m_complete, 4'b0001);
        chk("wr_drain_request", sdram_request, 1'b0);
        chk("wr_drain_wdata", sdram_wdata, 32'hDEADBEEF);
        chk("wr_drain_address", sdram_address, 26'h0001000);
        tick; tick;

        // Burst read, master 2: eight beats 0..7.
        set_master(2, 0, 26'h0000040, 32'h0, 4'hF, 1);
        serve(8, 32'h0, 0, 4'b0100, id);
        chk("burst_id", id, 4'd3);
        chk("burst_complete", m_complete, 4'b0100);
        chk("burst_flag", sdram_burst, 1'b1);
        tick; tick;

        // Foreign completion while busy for master 1.
        set_master(1, 0, 26'h0000300, 32'h0, 4'h3, 0);
        wait_grant(id);
        chk("inj_grant", id, 4'd2);
        sdram_complete = 4'd3;
        tick;
        sdram_complete = 4'd0;
        chk("inj_request", sdram_request, 1'b1);
        chk("inj_m_complete", m_complete, 4'b0100);
        tick;
        chk("inj_request2", sdram_request, 1'b1);
        chk("inj_master", sdram_master, 4'd2);
        serve(1, 32'hA5, 0, 4'b0010, id);
        tick; tick;

        // All four request at once after reset (last = 3); master 0 keeps re-requesting.
        reset = 1;
        tick;
        reset = 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_order[0] = 4'd1; exp_order[1] = 4'd2; exp_order[2] = 4'd3; exp_order[3] = 4'd4;
`else
        exp_order[0] = 4'd1; exp_order[1] = 4'd1; exp_order[2] = 4'd1; exp_order[3] = 4'd1;
`endif
        for (int i = 0; i < N; i++) begin
            set_master(i, 1, 26'(32'h100 * i), 32'hC0DE0000 + 32'(i), 4'hF, 0);
        end
        for (int t = 0; t < 4; t++) begin
            serve(1, 32'h100 + 32'(t), 1, 4'd0, id);
            chk("arb_order", id, exp_order[t]);
            if (id > 1) m_request[id-1] = 1'b0;
        end
`ifndef SDRAM_ARB_ROUND_ROBIN_EN
        chk("fixed_starved", m_request, 4'b1111);
`endif
        m_request = 0;
        repeat (4) tick;

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
